// File: rtl/id_regfile.sv
// id_regfile: writeback-to-decode register file with write-through read ports.
// Optional FP bank enabled by defining RF_FP_BANK_EN; default build is integer-only.
module id_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            Rst_n,
    input  logic [AW-1:0]   WB_ID_rd,
    input  logic [XLEN-1:0] WB_ID_res,
    input  logic            WB_ID_regwrite,
    input  logic            WB_ID_fpusrc,
    input  logic            hold,
    input  logic [AW-1:0]   rs1_addr,
    input  logic            rs1_fp,
    output logic [XLEN-1:0] rs1_data,
    input  logic [AW-1:0]   rs2_addr,
    input  logic            rs2_fp,
    output logic [XLEN-1:0] rs2_data,
    input  logic [AW-1:0]   dbg_addr,
    input  logic            dbg_fp,
    output logic [XLEN-1:0] dbg_data,
    output logic            rf_ready
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [AW:0] C_LAST = (AW+1)'(NREG-1);
    localparam logic [AW:0] C_ONE  = (AW+1)'(1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW:0]     r_clr_idx;
    logic [AW:0]     w_clr_nxt;
    logic            w_clr_we;
    logic [AW-1:0]   w_clr_addr;
    logic            r_ready;
    logic [XLEN-1:0] r_dbg_data;

    logic [XLEN-1:0] r_int [NREG];

    logic            w_commit;
    logic            w_int_we;
    logic            w_fp_we;
    logic [XLEN-1:0] w_rs1_fpv;
    logic [XLEN-1:0] w_rs2_fpv;
    logic [XLEN-1:0] w_dbg_fpv;

    assign w_clr_addr = r_clr_idx[AW-1:0];
    assign w_commit   = r_ready & WB_ID_regwrite & ~hold;
    assign w_int_we   = w_commit & ~WB_ID_fpusrc & (WB_ID_rd != '0);

`ifdef RF_FP_BANK_EN
    logic [XLEN-1:0] r_fp [NREG];

    assign w_fp_we   = w_commit & WB_ID_fpusrc;
    assign w_rs1_fpv = r_fp[rs1_addr];
    assign w_rs2_fpv = r_fp[rs2_addr];
    assign w_dbg_fpv = r_fp[dbg_addr];

    // FP bank: cleared by the sweep, then written by FP commits (f0 included)
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_fp[w_clr_addr] <= '0;
        end else if (w_fp_we) begin
            r_fp[WB_ID_rd] <= WB_ID_res;
        end
    end
`else
    assign w_fp_we   = 1'b0;
    assign w_rs1_fpv = '0;
    assign w_rs2_fpv = '0;
    assign w_dbg_fpv = '0;
`endif

    // Integer bank: cleared by the sweep, then written by integer commits
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_int[w_clr_addr] <= '0;
        end else if (w_int_we) begin
            r_int[WB_ID_rd] <= WB_ID_res;
        end
    end

    // Sweep FSM state, clear index and registered ready flag
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_nxt;
            r_ready   <= (r_state == READY);
        end
    end

    // Sweep next-state: one register per cycle, READY after the last index
    always_comb begin
        w_state_nxt = r_state;
        w_clr_nxt   = r_clr_idx;
        w_clr_we    = 1'b0;
        unique case (r_state)
            CLEAR: begin
                w_clr_we  = 1'b1;
                w_clr_nxt = r_clr_idx + C_ONE;
                if (r_clr_idx == C_LAST) begin
                    w_state_nxt = READY;
                end
            end
            READY: begin
                w_state_nxt = READY;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    // Read port 1: zero while clearing, x0 hardwired, write-through on commit
    always_comb begin
        rs1_data = '0;
        if (r_ready) begin
            if (rs1_fp) begin
                if (w_fp_we && (rs1_addr == WB_ID_rd)) begin
                    rs1_data = WB_ID_res;
                end else begin
                    rs1_data = w_rs1_fpv;
                end
            end else if (rs1_addr != '0) begin
                if (w_int_we && (rs1_addr == WB_ID_rd)) begin
                    rs1_data = WB_ID_res;
                end else begin
                    rs1_data = r_int[rs1_addr];
                end
            end
        end
    end

    // Read port 2: same behaviour as port 1
    always_comb begin
        rs2_data = '0;
        if (r_ready) begin
            if (rs2_fp) begin
                if (w_fp_we && (rs2_addr == WB_ID_rd)) begin
                    rs2_data = WB_ID_res;
                end else begin
                    rs2_data = w_rs2_fpv;
                end
            end else if (rs2_addr != '0) begin
                if (w_int_we && (rs2_addr == WB_ID_rd)) begin
                    rs2_data = WB_ID_res;
                end else begin
                    rs2_data = r_int[rs2_addr];
                end
            end
        end
    end

    // Debug port: registered array read, no bypass, zero until ready
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_dbg_data <= '0;
        end else if (!r_ready) begin
            r_dbg_data <= '0;
        end else if (dbg_fp) begin
            r_dbg_data <= w_dbg_fpv;
        end else if (dbg_addr == '0) begin
            r_dbg_data <= '0;
        end else begin
            r_dbg_data <= r_int[dbg_addr];
        end
    end

    assign dbg_data = r_dbg_data;
    assign rf_ready = r_ready;

endmodule
